// File: rtl/mips_mem_arbiter_pkg.sv
`default_nettype none
// mips_mem_arbiter_pkg: shared FSM state and grant encodings (rev 1.0)
package mips_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // One-hot grant {data, fetch} to side code
   function automatic logic gnt_side(input logic [1:0] gnt);
      return gnt[1] ? GNT_D : GNT_I;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_arbiter_rr_arb2.sv
`default_nettype none
// mips_mem_arbiter_rr_arb2: two-request round-robin arbiter, priority flips on each grant (rev 1.0)
module mips_mem_arbiter_rr_arb2
   import mips_mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

   logic prio_q;

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         gnt_o = (prio_q == GNT_D) ? 2'b10 : 2'b01;
      end else begin
         gnt_o = req_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= GNT_I;
      end else if (adv_i && (gnt_o != 2'b00)) begin
         // Next priority goes to whichever side was not just served
         prio_q <= (gnt_side(gnt_o) == GNT_D) ? GNT_I : GNT_D;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// mips_mem_arbiter: shares one memory port between MIPS fetch and load/store requesters (rev 1.0)
module mips_mem_arbiter
   import mips_mem_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_rvalid,
   input  logic [DW-1:0] m_rdata,
   output logic          stall,
   output logic          err
);

   localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   state_e        state_q;
   logic          gnt_q;
   logic [CW-1:0] cnt_q;
   logic          m_valid_q, m_we_q, i_ack_q, d_ack_q, err_q;
   logic [AW-1:0] m_addr_q;
   logic [DW-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
   logic [1:0]    arb_gnt;

   mips_mem_arbiter_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i ({d_req, i_req}),
      .adv_i (state_q == ST_IDLE),
      .gnt_o (arb_gnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= GNT_I;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_gnt != 2'b00) begin
                  gnt_q     <= gnt_side(arb_gnt);
                  m_valid_q <= 1'b1;
                  if (gnt_side(arb_gnt) == GNT_D) begin
                     m_we_q    <= d_we;
                     m_addr_q  <= d_addr;
                     m_wdata_q <= d_wdata;
                  end else begin
                     m_we_q    <= 1'b0;
                     m_addr_q  <= i_addr;
                     m_wdata_q <= '0;
                  end
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (m_rvalid) begin
                  if (gnt_q == GNT_D) begin
                     d_ack_q <= 1'b1;
                     if (!m_we_q) d_rdata_q <= m_rdata;
                  end else begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= m_rdata;
                  end
                  state_q <= ST_DONE;
               end else if ((TIMEOUT != 0) && (cnt_q == CW'(TO_LAST))) begin
                  // Abort: complete the access with zero data so the core is not hung
                  err_q <= 1'b1;
                  if (gnt_q == GNT_D) begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= '0;
                  end else begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= '0;
                  end
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_valid = m_valid_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign err     = err_q;
   assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
`default_nettype none
// tb_mips_mem_arbiter: directed self-checking bench for the fetch/data memory arbiter (rev 1.0)
module tb_mips_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, m_ready, m_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic        i_ack, d_ack, m_valid, m_we, stall, err;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mips_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_ack    (i_ack),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata),
      .stall    (stall),
      .err      (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      i_req = 0; d_req = 0; d_we = 0; m_ready = 0; m_rvalid = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
      next_cycle();
      next_cycle();
      sample();
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_we",    {31'd0, m_we},    32'd0);
      check("rst_acks",    {30'd0, i_ack, d_ack}, 32'd0);
      check("rst_err",     {31'd0, err},     32'd0);
      check("rst_m_addr",  m_addr,  32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_stall",   {31'd0, stall},   32'd0);
      next_cycle();
      reset = 1'b0;

      // Single fetch at minimum latency; d_wdata must not leak onto a fetch
      next_cycle(); i_req = 1; i_addr = 32'h40; d_wdata = 32'hFFFF_FFFF;
      sample();
      check("t1_c0_m_valid", {31'd0, m_valid}, 32'd0);
      check("t1_c0_stall",   {31'd0, stall},   32'd1);
      next_cycle(); m_ready = 1;
      sample();
      check("t1_c1_m_valid", {31'd0, m_valid}, 32'd1);
      check("t1_c1_m_addr",  m_addr,  32'h40);
      check("t1_c1_m_we",    {31'd0, m_we},    32'd0);
      check("t1_c1_m_wdata", m_wdata, 32'd0);
      next_cycle(); m_ready = 0; m_rvalid = 1; m_rdata = 32'h2008_0005;
      sample();
      check("t1_c2_m_valid", {31'd0, m_valid}, 32'd0);
      check("t1_c2_i_ack",   {31'd0, i_ack},   32'd0);
      check("t1_c2_stall",   {31'd0, stall},   32'd1);
      next_cycle(); m_rvalid = 0; m_rdata = 32'd0;
      sample();
      check("t1_c3_i_ack",   {31'd0, i_ack},   32'd1);
      check("t1_c3_d_ack",   {31'd0, d_ack},   32'd0);
      check("t1_c3_i_rdata", i_rdata, 32'h2008_0005);
      check("t1_c3_stall",   {31'd0, stall},   32'd0);
      next_cycle(); i_req = 0; d_wdata = 0;
      sample();
      check("t1_c4_i_ack",   {31'd0, i_ack},   32'd0);

      // Both requesters held high from reset: strict I,D,I,D alternation
      do_reset();
      for (int c = 0; c < 16; c++) begin
         next_cycle();
         if (c == 0) begin
            i_req = 1; d_req = 1; d_we = 0;
            i_addr = 32'h100; d_addr = 32'h200;
            m_ready = 1; m_rvalid = 1;
         end
         m_rdata = 32'h1000 + c;
         sample();
         check("t2_i_ack", {31'd0, i_ack}, {31'd0, (c % 8) == 3});
         check("t2_d_ack", {31'd0, d_ack}, {31'd0, (c % 8) == 7});
         if ((c % 4) == 1) check("t2_m_addr", m_addr, ((c % 8) == 1) ? 32'h100 : 32'h200);
         if ((c % 8) == 3) check("t2_i_rdata", i_rdata, 32'h1000 + c - 1);
         if ((c % 8) == 7) check("t2_d_rdata", d_rdata, 32'h1000 + c - 1);
      end
      next_cycle(); i_req = 0; d_req = 0; m_ready = 0; m_rvalid = 0;
      sample();
      check("t2_idle_m_valid", {31'd0, m_valid}, 32'd0);
      check("t2_idle_err",     {31'd0, err},     32'd0);

      // Store with back-pressure; inputs change mid-flight, m_rvalid in ISSUE ignored
      next_cycle(); d_req = 1; d_we = 1; d_addr = 32'h54; d_wdata = 32'h7; m_rdata = 32'hBAD;
      sample();
      check("t3_c0_m_valid", {31'd0, m_valid}, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         next_cycle();
         if (k == 2) begin d_addr = 32'h99; d_wdata = 32'h33; end
         if (k == 6) begin m_ready = 1; m_rvalid = 1; end
         sample();
         check("t3_m_valid", {31'd0, m_valid}, 32'd1);
         check("t3_m_addr",  m_addr,  32'h54);
         check("t3_m_wdata", m_wdata, 32'h7);
         check("t3_m_we",    {31'd0, m_we},    32'd1);
      end
      next_cycle(); m_ready = 0; m_rvalid = 0;
      sample();
      check("t3_c7_m_valid", {31'd0, m_valid}, 32'd0);
      check("t3_c7_d_ack",   {31'd0, d_ack},   32'd0);
      next_cycle(); m_rvalid = 1;
      sample();
      check("t3_c8_d_ack",   {31'd0, d_ack},   32'd0);
      check("t3_c8_stall",   {31'd0, stall},   32'd1);
      next_cycle(); m_rvalid = 0;
      sample();
      check("t3_c9_d_ack",   {31'd0, d_ack},   32'd1);
      check("t3_c9_i_ack",   {31'd0, i_ack},   32'd0);
      check("t3_c9_d_rdata", d_rdata, 32'h100E);
      check("t3_c9_stall",   {31'd0, stall},   32'd0);
      next_cycle(); d_req = 0; d_we = 0;
      sample();
      check("t3_c10_d_ack",  {31'd0, d_ack},   32'd0);

      // Load that never gets a response: abort after 4 WAIT cycles
      next_cycle(); d_req = 1; d_we = 0; d_addr = 32'h80; m_rdata = 32'h5555;
      sample();
      next_cycle(); m_ready = 1;
      sample();
      check("t4_c1_m_valid", {31'd0, m_valid}, 32'd1);
      for (int k = 2; k <= 5; k++) begin
         next_cycle(); m_ready = 0;
         sample();
         check("t4_wait_d_ack", {31'd0, d_ack}, 32'd0);
         check("t4_wait_err",   {31'd0, err},   32'd0);
      end
      next_cycle();
      sample();
      check("t4_c6_d_ack",   {31'd0, d_ack}, 32'd1);
      check("t4_c6_d_rdata", d_rdata, 32'd0);
      check("t4_c6_err",     {31'd0, err},   32'd1);
      next_cycle(); d_req = 0;
      sample();
      check("t4_c7_d_ack",   {31'd0, d_ack}, 32'd0);
      check("t4_c7_err",     {31'd0, err},   32'd1);
      // err remains set across a later successful fetch
      next_cycle(); i_req = 1; i_addr = 32'h44; m_ready = 1; m_rvalid = 1; m_rdata = 32'hABCD;
      sample();
      next_cycle(); sample();
      next_cycle(); sample();
      next_cycle(); sample();
      check("t4_fetch_i_ack",   {31'd0, i_ack}, 32'd1);
      check("t4_fetch_i_rdata", i_rdata, 32'hABCD);
      check("t4_fetch_err",     {31'd0, err},   32'd1);
      next_cycle(); i_req = 0; m_ready = 0; m_rvalid = 0;
      sample();

      // Reset while a data load sits in WAIT
      do_reset();
      sample();
      check("t5_err_cleared", {31'd0, err}, 32'd0);
      next_cycle(); d_req = 1; d_we = 0; d_addr = 32'h60;
      sample();
      next_cycle(); m_ready = 1;
      sample();
      check("t5_c1_m_valid", {31'd0, m_valid}, 32'd1);
      check("t5_c1_m_addr",  m_addr, 32'h60);
      next_cycle(); m_ready = 0; reset = 1;
      sample();
      check("t5_c2_m_valid", {31'd0, m_valid}, 32'd0);
      next_cycle(); reset = 0; d_req = 0;
      sample();
      check("t5_c3_m_valid", {31'd0, m_valid}, 32'd0);
      check("t5_c3_m_addr",  m_addr,  32'd0);
      check("t5_c3_acks",    {30'd0, i_ack, d_ack}, 32'd0);
      check("t5_c3_i_rdata", i_rdata, 32'd0);
      check("t5_c3_stall",   {31'd0, stall}, 32'd0);
      next_cycle(); m_rvalid = 1; m_rdata = 32'hDEAD;
      sample();
      next_cycle(); m_rvalid = 0;
      sample();
      check("t5_c5_d_ack",   {31'd0, d_ack}, 32'd0);
      check("t5_c5_i_ack",   {31'd0, i_ack}, 32'd0);
      check("t5_c5_d_rdata", d_rdata, 32'd0);
      check("t5_c5_m_valid", {31'd0, m_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
